// File: rtl/wb_burst_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_burst_master_pkg : shared state encoding and default parameters           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package wb_burst_master_pkg;

  localparam int DEF_ADDR_WIDTH      = 14;
  localparam int DEF_LEN_WIDTH       = 16;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_burst_master : Wishbone B4 pipelined burst master with ack timeout        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [31:0]           rd_data_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [31:0]           dat_o,
  input  logic [31:0]           dat_i,
  output logic                  we_o,
  output logic [3:0]            sel_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  stall_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam int                   TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]           OUT_LIMIT = 4'(MAX_OUTSTANDING);
  localparam logic [TMR_WIDTH-1:0] TMR_LAST  = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic                   burst_we;
  logic [LEN_WIDTH-1:0]   burst_len;
  logic [LEN_WIDTH-1:0]   issued;
  logic [LEN_WIDTH-1:0]   acked;
  logic [3:0]             outstanding;
  logic [TMR_WIDTH-1:0]   timer;

  logic accept;
  logic ack_hit;
  logic err_hit;
  logic ack_dec;
  logic rd_hit;
  logic timeout;

  assign cyc_o       = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign stb_o       = (state == ST_ISSUE) && (outstanding < OUT_LIMIT) && (!burst_we || wr_valid_i);
  assign accept      = stb_o & ~stall_i;
  assign wr_ready_o  = burst_we & accept;
  assign dat_o       = wr_data_i;
  assign we_o        = burst_we;
  assign sel_o       = 4'hF;
  assign busy_o      = (state != ST_IDLE);
  assign cmd_ready_o = (state == ST_IDLE);

  // Bus responses only count while the cycle is open.
  assign ack_hit = cyc_o & ack_i;
  assign err_hit = cyc_o & err_i;
  assign ack_dec = ack_hit && (outstanding != 4'd0);
  assign rd_hit  = ack_hit & ~burst_we & ~err_i;
  assign timeout = cyc_o && (outstanding != 4'd0) && !ack_hit && (timer == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      burst_we    <= 1'b0;
      burst_len   <= '0;
      issued      <= '0;
      acked       <= '0;
      outstanding <= 4'd0;
      timer       <= '0;
      adr_o       <= '0;
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      rd_valid_o <= rd_hit;
      if (rd_hit) rd_data_o <= dat_i;

      if (accept) begin
        adr_o  <= adr_o + 1'b1;
        issued <= issued + 1'b1;
      end
      if (ack_hit) acked <= acked + 1'b1;

      case ({accept, ack_dec})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase

      // Watchdog only runs while responses are owed and none arrives.
      if (!cyc_o || ack_hit || (outstanding == 4'd0)) timer <= '0;
      else                                            timer <= timer + 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_len_i != '0) begin
              state       <= ST_ISSUE;
              burst_we    <= cmd_we_i;
              adr_o       <= cmd_adr_i;
              burst_len   <= cmd_len_i;
              issued      <= '0;
              acked       <= '0;
              outstanding <= 4'd0;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        ST_ISSUE, ST_DRAIN: begin
          if (err_hit || timeout) begin
            state  <= ST_ABORT;
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end else if ((state == ST_ISSUE) && accept && ((issued + 1'b1) == burst_len)) begin
            state <= ST_DRAIN;
          end else if ((state == ST_DRAIN) && ack_hit && ((acked + 1'b1) == burst_len)) begin
            state  <= ST_IDLE;
            done_o <= 1'b1;
          end
        end
        ST_ABORT: begin
          state       <= ST_IDLE;
          outstanding <= 4'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_burst_master : directed bench with a pipelined Wishbone slave model    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_wb_burst_master;

  localparam int AW   = 14;
  localparam int LW   = 16;
  localparam int MAXO = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [LW-1:0] cmd_len_i;
  logic [31:0]   wr_data_i;
  logic          wr_valid_i, wr_ready_o;
  logic [31:0]   rd_data_o;
  logic          rd_valid_o, busy_o, done_o, err_o;
  logic [AW-1:0] adr_o;
  logic [31:0]   dat_o, dat_i;
  logic          we_o;
  logic [3:0]    sel_o;
  logic          stb_o, cyc_o, stall_i, ack_i, err_i;

  wb_burst_master #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .stall_i(stall_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    int            len;
    int            lag;
    int            st_start;
    int            st_len;
    logic          gap;
    int            err_idx;
    int            exp_acc;
    int            exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t          vecs [6];
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] pq_adr [$];
  int            pq_due [$];

  int   errors = 0;
  int   checks = 0;
  int   t = 0;
  int   r_acc, r_rd, r_max, r_done_t, r_last_resp, r_acc_t;
  logic r_done_seen, r_err, r_cyc_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle_inputs();
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    wr_data_i = '0; wr_valid_i = 1'b0; dat_i = '0;
    stall_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
  endtask

  // Slave acks strobe k 'lag' cycles after it was accepted, only while cyc_o is up.
  task automatic run_burst(input vec_t v);
    int            p, wr_k, n_ack;
    logic          prev_hold;
    logic [AW-1:0] prev_adr;
    logic [AW-1:0] ea;
    pq_adr.delete(); pq_due.delete();
    r_acc = 0; r_rd = 0; r_max = 0; r_done_t = -1; r_last_resp = -1; r_acc_t = -1;
    r_done_seen = 1'b0; r_err = 1'b0; r_cyc_done = 1'b1;
    wr_k = 0; n_ack = 0; prev_hold = 1'b0; prev_adr = '0;

    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr; cmd_len_i = LW'(v.len);
    tick();
    cmd_valid_i = 1'b0;
    check("busy_in_burst", busy_o, 1);
    check("cyc_in_burst", cyc_o, 1);
    check("cmd_ready_in_burst", cmd_ready_o, 0);

    p = 0;
    while (!r_done_seen && p < 300) begin
      stall_i    = (p >= v.st_start) && (p < v.st_start + v.st_len);
      wr_valid_i = v.gap ? (p % 2 == 0) : 1'b1;
      wr_data_i  = 32'hA500_0000 + 32'(wr_k);
      ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
      if (cyc_o && pq_due.size() > 0 && pq_due[0] <= p) begin
        if (n_ack == v.err_idx) err_i = 1'b1;
        else begin
          ack_i = 1'b1;
          dat_i = mem[pq_adr[0]];
        end
        void'(pq_adr.pop_front());
        void'(pq_due.pop_front());
        n_ack++;
        r_last_resp = t;
      end
      #1;
      if (prev_hold) begin
        check("stb_held_in_stall", stb_o, 1);
        check("adr_stable_in_stall", adr_o, 32'(prev_adr));
      end
      prev_hold = stb_o && stall_i;
      prev_adr  = adr_o;
      check("wr_ready", wr_ready_o, v.we & stb_o & ~stall_i);
      if (stb_o && !stall_i) begin
        ea = v.adr + AW'(r_acc);
        check("strobe_adr", adr_o, 32'(ea));
        check("strobe_we", we_o, v.we);
        check("strobe_sel", sel_o, 4'hF);
        if (v.we) begin
          check("strobe_dat", dat_o, 32'hA500_0000 + 32'(wr_k));
          mem[adr_o] = dat_o;
          wr_k++;
        end
        pq_adr.push_back(adr_o);
        pq_due.push_back(p + v.lag);
        r_acc++;
        r_acc_t = t;
        if (pq_adr.size() > r_max) r_max = pq_adr.size();
      end
      tick();
      p++;
      if (rd_valid_o) begin
        ea = v.adr + AW'(r_rd);
        check("rd_data", rd_data_o, 32'(ea));
        r_rd++;
      end
      if (done_o) begin
        r_done_seen = 1'b1;
        r_done_t    = t;
        r_err       = err_o;
        r_cyc_done  = cyc_o;
      end
    end
    idle_inputs();
    check("done_seen", r_done_seen, 1);
  endtask

  initial begin
    int n_done;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i);
    idle_inputs();
    rst = 1'b1;

    //           we    adr       len lag st_s st_l gap  err acc rd  err
    vecs[0] = '{1'b0, 14'h0100,  8,  1,  0,   0,  1'b0, -1, 8,  8,  1'b0};
    vecs[1] = '{1'b1, 14'h0200,  4,  1,  0,   0,  1'b1, -1, 4,  0,  1'b0};
    vecs[2] = '{1'b0, 14'h0300,  8,  3,  2,   5,  1'b0, -1, 8,  8,  1'b0};
    vecs[3] = '{1'b0, 14'h0180,  6,  1,  0,   0,  1'b0,  2, 4,  2,  1'b1};
    vecs[4] = '{1'b0, 14'h3FFE,  4,  1,  0,   0,  1'b0, -1, 4,  4,  1'b0};
    vecs[5] = '{1'b1, 14'h0280, 10,  6,  0,   0,  1'b0, -1, 10, 0,  1'b0};

    tick(); tick();
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i]);
      check("accepts", r_acc, vecs[i].exp_acc);
      check("rd_pulses", r_rd, vecs[i].exp_rd);
      check("done_err", r_err, vecs[i].exp_err);
      check("cyc_at_done", r_cyc_done, 0);
      check("done_latency", r_done_t, r_last_resp + 1);
      check("max_outstanding_ok", (r_max <= MAXO), 1);
      if (vecs[i].we) begin
        for (int k = 0; k < vecs[i].len; k++)
          check("mem_word", mem[vecs[i].adr + AW'(k)], 32'hA500_0000 + 32'(k));
      end
      tick();
      check("cyc_after_done", cyc_o, 0);
      check("done_one_cycle", done_o, 0);
      tick();
    end

    // Zero-length command: done next cycle, no bus cycle.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 14'h0010; cmd_len_i = '0;
    tick();
    idle_inputs();
    check("zlen_done", done_o, 1);
    check("zlen_err", err_o, 0);
    check("zlen_cyc", cyc_o, 0);
    check("zlen_busy", busy_o, 0);
    tick();
    check("zlen_cyc_after", cyc_o, 0);
    check("zlen_done_after", done_o, 0);

    // Single read never acked: abort TMO edges after the accepting edge.
    run_burst('{1'b0, 14'h0020, 1, 100000, 0, 0, 1'b0, -1, 1, 0, 1'b1});
    check("tmo_accepts", r_acc, 1);
    check("tmo_err", r_err, 1);
    check("tmo_cyc", r_cyc_done, 0);
    check("tmo_latency", r_done_t, r_acc_t + 1 + TMO);
    tick(); tick();

    // Reset in the middle of a burst.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 14'h0040; cmd_len_i = 16'd4;
    tick();
    cmd_valid_i = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_cyc", cyc_o, 1);
    rst = 1'b1;
    tick();
    check("midrst_cyc", cyc_o, 0);
    check("midrst_stb", stb_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_adr", adr_o, 0);
    rst = 1'b0;
    n_done = 0;
    repeat (25) begin
      tick();
      if (done_o) n_done++;
    end
    check("midrst_no_done", n_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
